// File: rtl/input_buffer_vc.sv
// Multi-VC input buffer: one write port feeding NUM_VC circular FIFOs in shared storage,
// one registered read per cycle, per-VC occupancy/credit status and sticky error flags.
module input_buffer_vc #(
  parameter int NUM_VC       = 4,
  parameter int VC_W         = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int PTR_W        = 4,
  parameter int DATA_WIDTH   = 70,
  parameter int AFULL_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic [VC_W-1:0]               wr_vc,
  input  logic                          wr_en,
  output logic                          ack,
  input  logic [VC_W-1:0]               rd_vc,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [VC_W-1:0]               dout_vc,
  output logic                          dout_valid,
  output logic [NUM_VC-1:0]             rok,
  output logic [NUM_VC-1:0]             full,
  output logic [NUM_VC-1:0]             afull,
  output logic [NUM_VC*(PTR_W+1)-1:0]   count,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int CNT_W     = PTR_W + 1;
  localparam int NUM_SLOTS = 2 ** VC_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(AFULL_THRESH);

  // Handshake: a write transfers in exactly the cycles where wr_en && ack; ack never
  // depends on rd_en. A read is accepted when rd_en targets a non-empty VC, and its flit
  // appears on dout with a single-cycle dout_valid pulse after the next rising edge.

  logic [DATA_WIDTH-1:0] mem [NUM_VC*FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr [NUM_VC];
  logic [CNT_W-1:0]      cnt    [NUM_VC];

  logic [NUM_SLOTS-1:0]  rok_pad, full_pad;
  logic [NUM_VC-1:0]     wr_hit, rd_hit;
  logic [PTR_W-1:0]      wr_ptr_sel, rd_ptr_sel;
  logic                  wr_in_range, rd_in_range, rd_acc;

  // Status is padded to the full index space so out-of-range VCs read as empty and not full.
  always_comb begin
    rok_pad     = '0;
    full_pad    = '0;
    wr_ptr_sel  = '0;
    rd_ptr_sel  = '0;
    wr_hit      = '0;
    rd_hit      = '0;
    wr_in_range = (int'(wr_vc) < NUM_VC);
    rd_in_range = (int'(rd_vc) < NUM_VC);
    for (int v = 0; v < NUM_VC; v++) begin
      rok_pad[v]  = rok[v];
      full_pad[v] = full[v];
    end
    ack    = wr_en && wr_in_range && !full_pad[wr_vc];
    rd_acc = rd_en && rd_in_range && rok_pad[rd_vc];
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_vc == VC_W'(v)) wr_ptr_sel = wr_ptr[v];
      if (rd_vc == VC_W'(v)) rd_ptr_sel = rd_ptr[v];
      wr_hit[v] = ack && (wr_vc == VC_W'(v));
      rd_hit[v] = rd_acc && (rd_vc == VC_W'(v));
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end else begin
        if (wr_hit[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (rd_hit[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        case ({wr_hit[v], rd_hit[v]})
          2'b10:   cnt[v] <= cnt[v] + 1'b1;
          2'b01:   cnt[v] <= cnt[v] - 1'b1;
          default: cnt[v] <= cnt[v];
        endcase
      end
    end

    assign rok[v]                     = (cnt[v] != '0);
    assign full[v]                    = (cnt[v] == DEPTH_C);
    assign afull[v]                   = ((DEPTH_C - cnt[v]) <= THRESH_C);
    assign count[v*CNT_W +: CNT_W]    = cnt[v];
  end

  always_ff @(posedge clk) begin
    if (ack) mem[{wr_vc, wr_ptr_sel}] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout          <= '0;
      dout_vc       <= '0;
      dout_valid    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout    <= mem[{rd_vc, rd_ptr_sel}];
        dout_vc <= rd_vc;
      end
      if (wr_en && !ack)  overflow_err  <= 1'b1;
      if (rd_en && !rd_acc) underflow_err <= 1'b1;
    end
  end

endmodule
